// File: rtl/dsp38_fir_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp38_fir_seq_if
// Brief    : Coefficient, sample, result and DSP38 feed/collect signal bundle.
// Revision : 1.0
// ============================================================================
interface dsp38_fir_seq_if;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [19:0] coef_data;
    logic        coef_err;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_data;
    logic        r_valid;
    logic        r_ready;
    logic [37:0] r_data;
    logic [19:0] dsp_a;
    logic [17:0] dsp_b;
    logic        dsp_load_acc;
    logic [2:0]  dsp_feedback;
    logic [5:0]  dsp_shift_right;
    logic        dsp_saturate_enable;
    logic        dsp_unsigned_a;
    logic        dsp_unsigned_b;
    logic [37:0] dsp_z;

    // master: the sequencer itself; slave: its surroundings (host, sink, DSP38)
    modport master (
        input  coef_we, coef_addr, coef_data, s_valid, s_data, r_ready, dsp_z,
        output coef_err, s_ready, r_valid, r_data, dsp_a, dsp_b, dsp_load_acc,
               dsp_feedback, dsp_shift_right, dsp_saturate_enable,
               dsp_unsigned_a, dsp_unsigned_b
    );

    modport slave (
        output coef_we, coef_addr, coef_data, s_valid, s_data, r_ready, dsp_z,
        input  coef_err, s_ready, r_valid, r_data, dsp_a, dsp_b, dsp_load_acc,
               dsp_feedback, dsp_shift_right, dsp_saturate_enable,
               dsp_unsigned_a, dsp_unsigned_b
    );
endinterface
`default_nettype wire

// File: rtl/dsp38_fir_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp38_fir_seq
// Brief    : Time-multiplexed FIR sequencer feeding one DSP38 in accumulate mode.
// Revision : 1.0
// ============================================================================
module dsp38_fir_seq #(
    parameter int TAPS        = 4,
    parameter int DSP_LATENCY = 2,
    parameter int SHIFT       = 0,
    parameter int SATURATE    = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    dsp38_fir_seq_if.master fir
);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MAC     = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;
    localparam logic [3:0] c_LAST_TAP   = 4'(TAPS - 1);
    localparam logic [1:0] c_LAST_DRAIN = 2'(DSP_LATENCY - 1);
    localparam logic [4:0] c_TAPS       = 5'(TAPS);

    logic [1:0]  r_state;
    logic [3:0]  r_tap;
    logic [1:0]  r_drain;
    logic        r_live;
    logic [19:0] r_coef [TAPS];
    logic [17:0] r_hist [TAPS];
    logic [37:0] r_data;
    logic        r_valid;
    logic        r_coef_err;

    logic        w_s_ready;
    logic        w_accept;
    logic        w_coef_ok;
    logic        w_coef_wr;
    logic        w_coef_reject;
    logic        w_mac;
    logic [19:0] w_dsp_a;
    logic [17:0] w_dsp_b;

    // r_live keeps S_READY low until the first edge after reset is released
    assign w_s_ready     = r_live && (r_state == c_ST_IDLE) && (!r_valid || fir.r_ready);
    assign w_accept      = fir.s_valid && w_s_ready;
    assign w_coef_ok     = (r_state == c_ST_IDLE) && ({1'b0, fir.coef_addr} < c_TAPS);
    assign w_coef_wr     = fir.coef_we && w_coef_ok;
    assign w_coef_reject = fir.coef_we && !w_coef_ok;
    assign w_mac         = (r_state == c_ST_MAC);

    always_comb begin
        w_dsp_a = '0;
        w_dsp_b = '0;
        if (w_mac) begin
            for (int i = 0; i < TAPS; i++) begin
                if (r_tap == 4'(i)) begin
                    w_dsp_a = r_coef[i];
                    w_dsp_b = r_hist[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_tap      <= '0;
            r_drain    <= '0;
            r_live     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_coef_err <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
                r_hist[i] <= '0;
            end
        end else begin
            r_live     <= 1'b1;
            r_coef_err <= w_coef_reject;

            for (int i = 0; i < TAPS; i++) begin
                if (w_coef_wr && (fir.coef_addr == 4'(i))) begin
                    r_coef[i] <= fir.coef_data;
                end
            end

            if (r_valid && fir.r_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_hist[0] <= fir.s_data;
                        for (int i = 1; i < TAPS; i++) begin
                            r_hist[i] <= r_hist[i-1];
                        end
                        r_tap   <= '0;
                        r_state <= c_ST_MAC;
                    end
                end
                c_ST_MAC: begin
                    if (r_tap == c_LAST_TAP) begin
                        r_drain <= '0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_tap <= r_tap + 4'd1;
                    end
                end
                c_ST_DRAIN: begin
                    // Z already holds the full sum on the last drain edge
                    if (r_drain == c_LAST_DRAIN) begin
                        r_data  <= fir.dsp_z;
                        r_valid <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign fir.s_ready             = w_s_ready;
    assign fir.r_valid             = r_valid;
    assign fir.r_data              = r_data;
    assign fir.coef_err            = r_coef_err;
    assign fir.dsp_a               = w_dsp_a;
    assign fir.dsp_b               = w_dsp_b;
    assign fir.dsp_load_acc        = w_mac && (r_tap == 4'd0);
    assign fir.dsp_feedback        = 3'b000;
    assign fir.dsp_shift_right     = 6'(SHIFT);
    assign fir.dsp_saturate_enable = (SATURATE != 0);
    assign fir.dsp_unsigned_a      = 1'b0;
    assign fir.dsp_unsigned_b      = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_dsp38_fir_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp38_fir_seq
// Brief    : Self-checking bench for dsp38_fir_seq with a behavioural DSP38 stub.
// Revision : 1.0
// ============================================================================
module tb_dsp38_fir_seq;
    localparam int TAPS = 4;
    localparam int LAT  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dsp38_fir_seq_if u_if ();

    dsp38_fir_seq #(
        .TAPS        (TAPS),
        .DSP_LATENCY (LAT),
        .SHIFT       (0),
        .SATURATE    (0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .fir   (u_if)
    );

    always #5 clk = ~clk;

    // DSP38 stub: signed MAC, accumulator register plus one output stage (LAT=2)
    longint st_acc = 0;
    longint st_z   = 0;
    always @(posedge clk) begin
        longint p;
        p = longint'($signed(u_if.dsp_a)) * longint'($signed(u_if.dsp_b));
        st_acc <= u_if.dsp_load_acc ? p : st_acc + p;
        st_z   <= st_acc;
    end
    assign u_if.dsp_z = st_z[37:0];

    // Reference model: the filter as a plain dot product over a sample window
    longint m_coef [TAPS];
    longint m_hist [TAPS];

    function automatic logic [37:0] m_push(input logic [17:0] s);
        longint sum = 0;
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = longint'($signed(s));
        for (int i = 0; i < TAPS; i++) sum += m_coef[i] * m_hist[i];
        return sum[37:0];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coef_wr(input logic [3:0] a, input logic [19:0] d);
        u_if.coef_we   = 1'b1;
        u_if.coef_addr = a;
        u_if.coef_data = d;
        step();
        u_if.coef_we = 1'b0;
        chk("coef_err_idle", u_if.coef_err, (int'(a) >= TAPS));
        if (int'(a) < TAPS) m_coef[int'(a)] = longint'($signed(d));
    endtask

    // Called one cycle after the accept edge; lat counts edges from accept
    task automatic wait_res(output logic [37:0] res, output int lat, output int loads);
        loads = int'(u_if.dsp_load_acc);
        lat   = 0;
        while (!u_if.r_valid && lat < 40) begin
            step();
            lat++;
            loads += int'(u_if.dsp_load_acc);
        end
        res = u_if.r_data;
    endtask

    task automatic run_sample(input logic [17:0] s, input logic wr, input logic [3:0] wa,
                              input logic [19:0] wd, output logic [37:0] res,
                              output int lat, output int loads);
        chk("s_ready_idle", u_if.s_ready, 1);
        u_if.s_valid   = 1'b1;
        u_if.s_data    = s;
        u_if.r_ready   = 1'b1;
        u_if.coef_we   = wr;
        u_if.coef_addr = wa;
        u_if.coef_data = wd;
        step();
        u_if.s_valid = 1'b0;
        u_if.coef_we = 1'b0;
        chk("coef_err_accept", u_if.coef_err, (wr && int'(wa) >= TAPS));
        if (wr && int'(wa) < TAPS) m_coef[int'(wa)] = longint'($signed(wd));
        wait_res(res, lat, loads);
        step();
        chk("r_valid_clear", u_if.r_valid, 0);
    endtask

    typedef struct {
        logic [TAPS-1:0][19:0] c;
        logic [17:0]           s;
        logic [37:0]           exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [8];
        logic [37:0] res, e1, e2;
        logic [17:0] d [20];
        logic [37:0] q [$];
        int          lat, loads, flag;

        vt[0] = '{{20'd4, 20'd3, 20'd2, 20'd1}, 18'd1, 38'd1};
        vt[1] = '{{20'd4, 20'd3, 20'd2, 20'd1}, 18'd0, 38'd2};
        vt[2] = '{{20'd4, 20'd3, 20'd2, 20'd1}, 18'd0, 38'd3};
        vt[3] = '{{20'd4, 20'd3, 20'd2, 20'd1}, 18'd0, 38'd4};
        vt[4] = '{{4{20'hFFFFF}}, 18'h20000, 38'h0_0002_0000};
        vt[5] = '{{4{20'hFFFFF}}, 18'h20000, 38'h0_0004_0000};
        vt[6] = '{{4{20'hFFFFF}}, 18'h20000, 38'h0_0006_0000};
        vt[7] = '{{4{20'hFFFFF}}, 18'h20000, 38'h0_0008_0000};

        u_if.coef_we = 0; u_if.coef_addr = 0; u_if.coef_data = 0;
        u_if.s_valid = 0; u_if.s_data = 0; u_if.r_ready = 1;
        m_clear();

        // Reset state
        step();
        step();
        chk("rst_s_ready", u_if.s_ready, 0);
        chk("rst_r_valid", u_if.r_valid, 0);
        chk("rst_r_data", u_if.r_data, 0);
        chk("rst_coef_err", u_if.coef_err, 0);
        chk("rst_dsp_a", u_if.dsp_a, 0);
        chk("rst_dsp_b", u_if.dsp_b, 0);
        chk("rst_load", u_if.dsp_load_acc, 0);
        chk("const_feedback", u_if.dsp_feedback, 0);
        chk("const_shift", u_if.dsp_shift_right, 0);
        chk("const_sat", u_if.dsp_saturate_enable, 0);
        chk("const_unsigned", {u_if.dsp_unsigned_a, u_if.dsp_unsigned_b}, 0);
        reset = 1'b0;
        step();
        chk("s_ready_after_reset", u_if.s_ready, 1);

        // Impulse response and negative arithmetic from the vector table
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < TAPS; i++) coef_wr(4'(i), vt[v].c[i]);
            run_sample(vt[v].s, 1'b0, 4'd0, 20'd0, res, lat, loads);
            chk($sformatf("vec%0d_res", v), res, vt[v].exp);
            chk($sformatf("vec%0d_model", v), res, m_push(vt[v].s));
            chk($sformatf("vec%0d_latency", v), lat, TAPS + LAT);
            chk($sformatf("vec%0d_loads", v), loads, 1);
        end

        // Backpressure: result held, next sample accepted on the handshake edge
        u_if.r_ready = 1'b0;
        u_if.s_valid = 1'b1;
        u_if.s_data  = 18'd100;
        step();
        e1 = m_push(18'd100);
        u_if.s_data = 18'd200;
        wait_res(res, lat, loads);
        chk("bp_latency", lat, TAPS + LAT);
        chk("bp_res1", res, e1);
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (u_if.r_data !== e1 || u_if.r_valid !== 1'b1 || u_if.s_ready !== 1'b0) flag++;
        end
        chk("bp_hold_stable", flag, 0);
        u_if.r_ready = 1'b1;
        #1;
        chk("bp_s_ready_on_handshake", u_if.s_ready, 1);
        step();
        u_if.s_valid = 1'b0;
        e2 = m_push(18'd200);
        chk("bp_r_valid_cleared", u_if.r_valid, 0);
        wait_res(res, lat, loads);
        chk("bp_latency2", lat, TAPS + LAT);
        chk("bp_res2", res, e2);
        step();

        // Coefficient write and sample during MAC are both ignored
        u_if.s_valid = 1'b1;
        u_if.s_data  = 18'd300;
        step();
        e1 = m_push(18'd300);
        u_if.coef_we   = 1'b1;
        u_if.coef_addr = 4'd0;
        u_if.coef_data = 20'h00077;
        u_if.s_data    = 18'h00555;
        step();
        u_if.coef_we = 1'b0;
        u_if.s_valid = 1'b0;
        chk("coef_err_mac", u_if.coef_err, 1);
        step();
        chk("coef_err_pulse_end", u_if.coef_err, 0);
        wait_res(res, lat, loads);
        chk("mac_write_res", res, e1);
        step();
        run_sample(18'd301, 1'b0, 4'd0, 20'd0, res, lat, loads);
        chk("mac_ignore_followup", res, m_push(18'd301));
        coef_wr(4'd9, 20'h12345);
        step();
        chk("coef_err_addr_end", u_if.coef_err, 0);
        run_sample(18'h3FFFF, 1'b0, 4'd0, 20'd0, res, lat, loads);
        chk("bad_addr_followup", res, m_push(18'h3FFFF));

        // Reset in MAC cycle 2
        for (int i = 0; i < TAPS; i++) coef_wr(4'(i), 20'(i + 5));
        u_if.s_valid = 1'b1;
        u_if.s_data  = 18'd1000;
        step();
        u_if.s_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_dsp_a", u_if.dsp_a, 0);
        chk("mid_rst_dsp_b", u_if.dsp_b, 0);
        chk("mid_rst_load", u_if.dsp_load_acc, 0);
        chk("mid_rst_s_ready", u_if.s_ready, 0);
        chk("mid_rst_r_valid", u_if.r_valid, 0);
        step();
        step();
        reset = 1'b0;
        m_clear();
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (u_if.r_valid !== 1'b0) flag++;
        end
        chk("mid_rst_no_result", flag, 0);
        run_sample(18'd1, 1'b0, 4'd0, 20'd0, res, lat, loads);
        chk("mid_rst_impulse_zero", res, 0);
        chk("mid_rst_model", res, m_push(18'd1));

        // Back-to-back random stream
        for (int i = 0; i < TAPS; i++) coef_wr(4'(i), 20'($urandom));
        for (int i = 0; i < 20; i++) d[i] = 18'($urandom);
        u_if.r_ready = 1'b1;
        u_if.s_valid = 1'b1;
        u_if.s_data  = d[0];
        flag  = 0;
        loads = 0;
        for (int k = 0; k < 20 * (TAPS + LAT + 1); k++) begin
            step();
            loads += int'(u_if.dsp_load_acc);
            if (k % 7 == 0) begin
                q.push_back(m_push(d[k/7]));
                if (k / 7 + 1 < 20) u_if.s_data = d[k/7 + 1];
                else u_if.s_valid = 1'b0;
            end
            if (u_if.r_valid !== (k % 7 == 6)) flag++;
            if (k % 7 == 6 && q.size() > 0) chk($sformatf("b2b_res%0d", k / 7), u_if.r_data, q.pop_front());
        end
        chk("b2b_valid_pattern", flag, 0);
        chk("b2b_loads", loads, 20);
        step();

        // Random samples with gaps and occasional writes alongside the accept
        for (int n = 0; n < 12; n++) begin
            logic       wr;
            logic [3:0] wa;
            wr = 1'($urandom);
            wa = 4'($urandom_range(0, 5));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            run_sample(18'($urandom), wr, wa, 20'($urandom), res, lat, loads);
            chk($sformatf("rand%0d_res", n), res, m_push(u_if.s_data));
            chk($sformatf("rand%0d_latency", n), lat, TAPS + LAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
